div_rs: RTL and testbench

Repeated-subtraction unsigned divider with an integrated controller and datapath. It computes the quotient and remainder of two WIDTH-bit operands. Both operands are loaded over one shared data bus on consecutive cycles, and completion is reported with a single-cycle `done` pulse. It is the inverse arithmetic unit of the team's repeated-addition multiplier: it undoes a product the same way that unit builds one, by counting iterations against a zero/compare test. It sits beside the multiplier behind the same start/done handshake.

---
 rtl/div_rs.sv | 85 ++++++++
 tb/tb_div_rs.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_rs.sv
// rtl/div_rs.sv - repeated-subtraction unsigned divider, start/done handshake
// Dividend and divisor arrive on data_in in consecutive cycles; results held until next start.
module div_rs #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_DVS = 2'd1,
    CALC     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;

  assign quotient  = q_reg;
  assign remainder = r_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r_reg       <= data_in;
            q_reg       <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD_DVS;
          end
        end
        LOAD_DVS: begin
          d_reg <= data_in;
          state <= CALC;
        end
        CALC: begin
          // Zero divisor reports a saturated quotient and leaves the dividend in R.
          if (d_reg == '0) begin
            div_by_zero <= 1'b1;
            q_reg       <= {WIDTH{1'b1}};
            done        <= 1'b1;
            state       <= DONE;
          end else if (r_reg >= d_reg) begin
            r_reg <= r_reg - d_reg;
            q_reg <= q_reg + 1'b1;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_rs.sv
// tb/tb_div_rs.sv - directed-vector bench for div_rs (WIDTH 16 and WIDTH 8 instances)
module tb_div_rs;

  logic        clock = 1'b0;
  logic        reset;
  logic        st;
  logic [15:0] dat;
  logic        sel;

  logic        start16, start8;
  logic [15:0] q16, r16;
  logic        done16, busy16, dz16;
  logic [7:0]  q8, r8;
  logic        done8, busy8, dz8;

  logic [15:0] o_q, o_r;
  logic        o_done, o_busy, o_dz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  assign start16 = sel ? 1'b0 : st;
  assign start8  = sel ? st : 1'b0;
  assign o_q     = sel ? {8'd0, q8} : q16;
  assign o_r     = sel ? {8'd0, r8} : r16;
  assign o_done  = sel ? done8 : done16;
  assign o_busy  = sel ? busy8 : busy16;
  assign o_dz    = sel ? dz8 : dz16;

  div_rs #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start16), .data_in(dat),
    .quotient(q16), .remainder(r16), .done(done16), .busy(busy16), .div_by_zero(dz16)
  );

  div_rs #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .data_in(dat[7:0]),
    .quotient(q8), .remainder(r8), .done(done8), .busy(busy8), .div_by_zero(dz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Called at the negedge of cycle N+1; counts cycles until done, checking busy meanwhile.
  task automatic wait_done(input string tag, input int elat);
    int cnt     = 1;
    bit busy_ok = 1'b1;
    while (!o_done && cnt < 600) begin
      if (!o_busy) busy_ok = 1'b0;
      @(negedge clock);
      cnt++;
    end
    check({tag, "_latency"}, cnt, elat);
    check({tag, "_busy_span"}, busy_ok, 1);
    check({tag, "_busy_at_done"}, o_busy, 1);
  endtask

  task automatic run_div(input string tag, input logic s8, input logic [15:0] dividend,
                         input logic [15:0] divisor, input logic [15:0] eq,
                         input logic [15:0] er, input logic edz, input int elat);
    @(negedge clock);
    sel = s8;
    st  = 1'b1;
    dat = dividend;
    @(negedge clock);
    st  = 1'b0;
    dat = divisor;
    check({tag, "_dz_clear"}, o_dz, 0);
    wait_done(tag, elat);
    check({tag, "_q"}, o_q, eq);
    check({tag, "_r"}, o_r, er);
    check({tag, "_dz"}, o_dz, edz);
    @(negedge clock);
    check({tag, "_done_drop"}, o_done, 0);
    check({tag, "_idle"}, o_busy, 0);
    check({tag, "_q_hold"}, o_q, eq);
  endtask

  initial begin
    reset = 1'b1;
    st    = 1'b0;
    dat   = '0;
    sel   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_q", q16, 0);
    check("rst_r", r16, 0);
    check("rst_done", done16, 0);
    check("rst_busy", busy16, 0);
    check("rst_dz", dz16, 0);
    reset = 1'b0;

    run_div("d100_7", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    run_div("d5_9", 1'b0, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 3);
    run_div("d9_9", 1'b0, 16'd9, 16'd9, 16'd1, 16'd0, 1'b0, 4);
    run_div("d1234_0", 1'b0, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 3);
    run_div("d0_5", 1'b0, 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 3);
    run_div("w8_255_1", 1'b1, 16'd255, 16'd1, 16'd255, 16'd0, 1'b0, 258);

    // Reset landing in the middle of CALC.
    @(negedge clock);
    sel = 1'b0;
    st  = 1'b1;
    dat = 16'd100;
    @(negedge clock);
    st  = 1'b0;
    dat = 16'd7;
    repeat (3) @(negedge clock);
    check("mid_busy", busy16, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_q", q16, 0);
    check("mid_rst_r", r16, 0);
    check("mid_rst_done", done16, 0);
    check("mid_rst_busy", busy16, 0);
    check("mid_rst_dz", dz16, 0);
    reset = 1'b0;
    run_div("d20_6", 1'b0, 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 6);

    // start held high across two back-to-back divisions.
    @(negedge clock);
    sel = 1'b0;
    st  = 1'b1;
    dat = 16'd40;
    @(negedge clock);
    dat = 16'd8;
    wait_done("hold1", 8);
    check("hold1_q", q16, 5);
    check("hold1_r", r16, 0);
    @(negedge clock);
    check("hold_idle_done", done16, 0);
    check("hold_idle_busy", busy16, 0);
    dat = 16'd9;
    @(negedge clock);
    check("hold2_accept", busy16, 1);
    dat = 16'd4;
    wait_done("hold2", 5);
    check("hold2_q", q16, 2);
    check("hold2_r", r16, 1);
    st = 1'b0;
    @(negedge clock);
    check("hold2_done_drop", done16, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
